// File: rtl/div_pkg.sv
// Shared definitions for the multi-cycle restoring divider.
// Contents: operand width, iteration counter width and the sequencer state enum.
package div_pkg;

    localparam int DIV_W     = 32;
    localparam int DIV_CNT_W = $clog2(DIV_W + 1);

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        ITER,
        FIX,
        DONE
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring shift/subtract step.
// Ports:
//   a     - partial remainder A (WIDTH+1 bits)
//   q     - dividend/quotient shift register Q (WIDTH bits)
//   m     - divisor M, zero-extended (WIDTH+1 bits)
//   new_a - A after shift and conditional restore
//   new_q - Q shifted left with the new quotient bit in bit 0
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_W
) (
    input  logic [WIDTH:0]   a,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH:0]   m,
    output logic [WIDTH:0]   new_a,
    output logic [WIDTH-1:0] new_q
);

    logic [WIDTH:0]   a_shifted;
    logic [WIDTH+1:0] trial;
    logic             fits;

    assign a_shifted = {a[WIDTH-1:0], q[WIDTH-1]};

    // The subtraction carries one guard bit above the 33-bit trial so that the
    // full A register takes part; A stays below M, so A[WIDTH] is zero in use
    // and trial[WIDTH:0] is exactly the 33-bit difference.
    assign trial = {a, q[WIDTH-1]} - {1'b0, m};
    assign fits  = ~trial[WIDTH+1];

    assign new_a = fits ? trial[WIDTH:0] : a_shifted;
    assign new_q = {q[WIDTH-2:0], fits};

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle restoring divider controller (signed/unsigned) for the DIV path.
// One shift/subtract step per clock through a shared div_step datapath.
// Ports:
//   clock, reset          - rising-edge clock, synchronous active-high reset
//   start                 - request, sampled only in IDLE
//   signed_op             - 1 = two's-complement operands (sampled with start)
//   dividend, divisor     - operands (sampled with start)
//   busy                  - high from PREP through FIX
//   done                  - one-cycle pulse when results are valid
//   dbz                   - divide-by-zero flag, held until next start
//   quotient, remainder   - LO/HI results, held until overwritten
//
// state | meaning
// IDLE  | waiting for start
// PREP  | divide-by-zero check, take operand magnitudes, load A/Q/M
// ITER  | WIDTH restoring steps, one per cycle
// FIX   | apply result signs, write quotient/remainder
// DONE  | done pulse
module div_sequencer
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic             dbz,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    div_state_t state, next_state;

    logic [WIDTH-1:0] dvd_r, dvs_r;
    logic             sop_r, qsign_r, rsign_r;
    logic [WIDTH:0]   a_r, m_r;
    logic [WIDTH-1:0] q_r;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH:0]   step_a;
    logic [WIDTH-1:0] step_q;
    logic [WIDTH-1:0] dvd_mag, dvs_mag;
    logic             last_step;

    // Negating 0x80000000 yields 0x80000000, which is the correct unsigned magnitude.
    assign dvd_mag   = (sop_r && dvd_r[WIDTH-1]) ? -dvd_r : dvd_r;
    assign dvs_mag   = (sop_r && dvs_r[WIDTH-1]) ? -dvs_r : dvs_r;
    assign last_step = (cnt == CNT_W'(WIDTH - 1));

    div_step #(.WIDTH(WIDTH)) u_step (
        .a     (a_r),
        .q     (q_r),
        .m     (m_r),
        .new_a (step_a),
        .new_q (step_q)
    );

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = PREP;
            PREP:    next_state = (dvs_r == '0) ? DONE : ITER;
            ITER:    if (last_step) next_state = FIX;
            FIX:     next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            dvd_r     <= '0;
            dvs_r     <= '0;
            sop_r     <= 1'b0;
            qsign_r   <= 1'b0;
            rsign_r   <= 1'b0;
            a_r       <= '0;
            q_r       <= '0;
            m_r       <= '0;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            dbz       <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            // Both flags are registered from next_state so they line up with the state.
            busy <= (next_state == PREP) || (next_state == ITER) || (next_state == FIX);
            done <= (next_state == DONE);
            case (state)
                IDLE: begin
                    if (start) begin
                        dvd_r   <= dividend;
                        dvs_r   <= divisor;
                        sop_r   <= signed_op;
                        qsign_r <= (dividend[WIDTH-1] ^ divisor[WIDTH-1]) & signed_op;
                        rsign_r <= dividend[WIDTH-1] & signed_op;
                        dbz     <= 1'b0;
                    end
                end
                PREP: begin
                    if (dvs_r == '0) begin
                        quotient  <= '1;
                        remainder <= dvd_r;
                        dbz       <= 1'b1;
                    end else begin
                        a_r <= '0;
                        q_r <= dvd_mag;
                        m_r <= {1'b0, dvs_mag};
                        cnt <= '0;
                    end
                end
                ITER: begin
                    a_r <= step_a;
                    q_r <= step_q;
                    cnt <= cnt + 1'b1;
                end
                FIX: begin
                    quotient  <= qsign_r ? -q_r : q_r;
                    remainder <= rsign_r ? -a_r[WIDTH-1:0] : a_r[WIDTH-1:0];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_sequencer.sv
module tb_div_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        signed_op = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        busy, done, dbz;
    logic [31:0] quotient, remainder;

    int n_vec = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    div_sequencer dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .signed_op (signed_op),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .dbz       (dbz),
        .quotient  (quotient),
        .remainder (remainder)
    );

    // Starts one division and returns the cycle (counted from the accepting edge)
    // in which done was observed; gives up at 100 cycles.
    task automatic run_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                           output int cyc, output logic busy_c1, output logic busy_done);
        @(negedge clock);
        signed_op = s; dividend = a; divisor = b; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        cyc = 1;
        busy_c1 = busy;
        while (!done && cyc < 100) begin
            @(negedge clock);
            cyc++;
        end
        busy_done = busy;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        n_vec++; if (busy !== 1'b0)      begin n_err++; $display("FAIL reset_busy got %0b want 0", busy); end
        n_vec++; if (done !== 1'b0)      begin n_err++; $display("FAIL reset_done got %0b want 0", done); end
        n_vec++; if (dbz !== 1'b0)       begin n_err++; $display("FAIL reset_dbz got %0b want 0", dbz); end
        n_vec++; if (quotient !== 32'h0) begin n_err++; $display("FAIL reset_quot got %h want 0", quotient); end
        n_vec++; if (remainder !== 32'h0) begin n_err++; $display("FAIL reset_rem got %h want 0", remainder); end
        reset = 1'b0;
    endtask

    task automatic test_unsigned();
        int   cyc;
        logic b1, bd;
        run_div(1'b0, 32'd100, 32'd7, cyc, b1, bd);
        n_vec++; if (cyc !== 35)          begin n_err++; $display("FAIL u100_7_latency got %0d want 35", cyc); end
        n_vec++; if (quotient !== 32'd14) begin n_err++; $display("FAIL u100_7_quot got %h want 0000000e", quotient); end
        n_vec++; if (remainder !== 32'd2) begin n_err++; $display("FAIL u100_7_rem got %h want 00000002", remainder); end
        n_vec++; if (dbz !== 1'b0)        begin n_err++; $display("FAIL u100_7_dbz got %0b want 0", dbz); end
        n_vec++; if (b1 !== 1'b1)         begin n_err++; $display("FAIL u100_7_busy_c1 got %0b want 1", b1); end
        n_vec++; if (bd !== 1'b0)         begin n_err++; $display("FAIL u100_7_busy_done got %0b want 0", bd); end
        @(negedge clock);
        n_vec++; if (done !== 1'b0)       begin n_err++; $display("FAIL u100_7_done_pulse got %0b want 0", done); end

        run_div(1'b0, 32'hFFFF_FFFF, 32'd1, cyc, b1, bd);
        n_vec++; if (quotient !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL uffff_1_quot got %h want ffffffff", quotient); end
        n_vec++; if (remainder !== 32'h0)        begin n_err++; $display("FAIL uffff_1_rem got %h want 00000000", remainder); end
    endtask

    task automatic test_dbz();
        int   cyc;
        logic b1, bd;
        run_div(1'b0, 32'h1234, 32'h0, cyc, b1, bd);
        n_vec++; if (cyc !== 2)                  begin n_err++; $display("FAIL dbz_latency got %0d want 2", cyc); end
        n_vec++; if (dbz !== 1'b1)               begin n_err++; $display("FAIL dbz_flag got %0b want 1", dbz); end
        n_vec++; if (quotient !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL dbz_quot got %h want ffffffff", quotient); end
        n_vec++; if (remainder !== 32'h1234)     begin n_err++; $display("FAIL dbz_rem got %h want 00001234", remainder); end
        repeat (3) @(negedge clock);
        n_vec++; if (dbz !== 1'b1)               begin n_err++; $display("FAIL dbz_held got %0b want 1", dbz); end
    endtask

    task automatic test_signed();
        int   cyc;
        logic b1, bd;
        run_div(1'b1, 32'hFFFF_FFF9, 32'd2, cyc, b1, bd);
        n_vec++; if (cyc !== 35)                 begin n_err++; $display("FAIL sm7_2_latency got %0d want 35", cyc); end
        n_vec++; if (dbz !== 1'b0)               begin n_err++; $display("FAIL sm7_2_dbz got %0b want 0", dbz); end
        n_vec++; if (quotient !== 32'hFFFF_FFFD) begin n_err++; $display("FAIL sm7_2_quot got %h want fffffffd", quotient); end
        n_vec++; if (remainder !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL sm7_2_rem got %h want ffffffff", remainder); end

        run_div(1'b1, 32'd7, 32'hFFFF_FFFE, cyc, b1, bd);
        n_vec++; if (quotient !== 32'hFFFF_FFFD) begin n_err++; $display("FAIL s7_m2_quot got %h want fffffffd", quotient); end
        n_vec++; if (remainder !== 32'd1)        begin n_err++; $display("FAIL s7_m2_rem got %h want 00000001", remainder); end

        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, cyc, b1, bd);
        n_vec++; if (quotient !== 32'h8000_0000) begin n_err++; $display("FAIL smin_m1_quot got %h want 80000000", quotient); end
        n_vec++; if (remainder !== 32'h0)        begin n_err++; $display("FAIL smin_m1_rem got %h want 00000000", remainder); end
        n_vec++; if (dbz !== 1'b0)               begin n_err++; $display("FAIL smin_m1_dbz got %0b want 0", dbz); end
    endtask

    task automatic test_ignore_start();
        int          cyc;
        int          n_done;
        int          done_cyc;
        logic [31:0] q_at, r_at;
        n_done = 0; done_cyc = 0; q_at = '0; r_at = '0;
        @(negedge clock);
        signed_op = 1'b0; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (cyc = 1; cyc <= 60; cyc++) begin
            if (cyc > 1) @(negedge clock);
            if (cyc == 10) begin
                start = 1'b1; signed_op = 1'b1; dividend = 32'd55; divisor = 32'd5;
            end
            if (cyc == 11) start = 1'b0;
            if (done) begin
                n_done++;
                done_cyc = cyc;
                q_at = quotient;
                r_at = remainder;
            end
        end
        n_vec++; if (n_done !== 1)        begin n_err++; $display("FAIL ign_done_count got %0d want 1", n_done); end
        n_vec++; if (done_cyc !== 35)     begin n_err++; $display("FAIL ign_latency got %0d want 35", done_cyc); end
        n_vec++; if (q_at !== 32'd14)     begin n_err++; $display("FAIL ign_quot got %h want 0000000e", q_at); end
        n_vec++; if (r_at !== 32'd2)      begin n_err++; $display("FAIL ign_rem got %h want 00000002", r_at); end
    endtask

    task automatic test_reset_mid();
        int   cyc;
        logic b1, bd;
        @(negedge clock);
        signed_op = 1'b0; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (19) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        n_vec++; if (busy !== 1'b0)       begin n_err++; $display("FAIL rmid_busy got %0b want 0", busy); end
        n_vec++; if (done !== 1'b0)       begin n_err++; $display("FAIL rmid_done got %0b want 0", done); end
        n_vec++; if (dbz !== 1'b0)        begin n_err++; $display("FAIL rmid_dbz got %0b want 0", dbz); end
        n_vec++; if (quotient !== 32'h0)  begin n_err++; $display("FAIL rmid_quot got %h want 0", quotient); end
        n_vec++; if (remainder !== 32'h0) begin n_err++; $display("FAIL rmid_rem got %h want 0", remainder); end
        reset = 1'b0;
        run_div(1'b0, 32'd9, 32'd3, cyc, b1, bd);
        n_vec++; if (cyc !== 35)          begin n_err++; $display("FAIL rmid_9_3_latency got %0d want 35", cyc); end
        n_vec++; if (quotient !== 32'd3)  begin n_err++; $display("FAIL rmid_9_3_quot got %h want 00000003", quotient); end
        n_vec++; if (remainder !== 32'd0) begin n_err++; $display("FAIL rmid_9_3_rem got %h want 00000000", remainder); end
    endtask

    // start held high: the copy seen during the DONE cycle is dropped and the next
    // division is accepted one cycle later, so done pulses are WIDTH+4 apart.
    task automatic test_back_to_back();
        int cyc;
        int first;
        @(negedge clock);
        signed_op = 1'b0; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
        @(negedge clock);
        signed_op = 1'b1; dividend = 32'd7; divisor = 32'hFFFF_FFFE;
        cyc = 1;
        while (!done && cyc < 200) begin @(negedge clock); cyc++; end
        first = cyc;
        n_vec++; if (first !== 35)        begin n_err++; $display("FAIL b2b_first got %0d want 35", first); end
        n_vec++; if (quotient !== 32'd14) begin n_err++; $display("FAIL b2b_first_quot got %h want 0000000e", quotient); end
        @(negedge clock);
        cyc++;
        while (!done && cyc < 200) begin @(negedge clock); cyc++; end
        start = 1'b0;
        n_vec++; if (cyc - first !== 36)         begin n_err++; $display("FAIL b2b_gap got %0d want 36", cyc - first); end
        n_vec++; if (quotient !== 32'hFFFF_FFFD) begin n_err++; $display("FAIL b2b_second_quot got %h want fffffffd", quotient); end
        n_vec++; if (remainder !== 32'd1)        begin n_err++; $display("FAIL b2b_second_rem got %h want 00000001", remainder); end
        repeat (3) @(negedge clock);
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_dbz();
        test_signed();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
